// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one full cipher round per clock around a single state register,
// with on-the-fly key expansion so no round-key storage is needed.
`timescale 1ns/1ps

module aes128_enc_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] pt_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic         busy
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes128_enc_iter: only NR=10 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    // Forward S-box, entry b at bits [8*(255-b)+7 -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        end
        return r;
    endfunction

    // Row r of the output takes column (c + r) mod 4 of the input.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;

    logic [31:0]  sub_w, t_w, nk0, nk1, nk2, nk3;
    logic [127:0] nk, sr, round_out;
    logic         last_rnd;

    // Key schedule step and round function, both derived from the current registers.
    always_comb begin
        sub_w     = {sbox(rk_q[23:16]), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
        t_w       = sub_w ^ {rcon_q, 24'h0};
        nk0       = rk_q[127:96] ^ t_w;
        nk1       = rk_q[95:64] ^ nk0;
        nk2       = rk_q[63:32] ^ nk1;
        nk3       = rk_q[31:0] ^ nk2;
        nk        = {nk0, nk1, nk2, nk3};
        sr        = shift_rows(sub_bytes(state_q));
        last_rnd  = (rnd_q == 4'(NR));
        round_out = last_rnd ? (sr ^ nk) : (mix_cols(sr) ^ nk);
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = pt_in ^ key_in;
                    rk_d    = key_in;
                    rcon_d  = 8'h01;
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out;
                rk_d    = nk;
                rnd_d   = rnd_q + 4'd1;
                rcon_d  = xtime(rcon_q);
                if (last_rnd) begin
                    ct_d  = round_out;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rcon_q  <= 8'h01;
            rnd_q   <= '0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == ROUND);
    assign out_valid = (fsm_q == DONE);
    assign ct_out    = ct_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench for aes128_enc_iter: known-answer vectors, backpressure, back-to-back, reset and random
// blocks against a byte-array AES-128 model built from GF(2^8) arithmetic.
`timescale 1ns/1ps

module tb_aes128_enc_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] key_in, pt_in, ct_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_t [256];

    always #5 clk = ~clk;

    aes128_enc_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .pt_in     (pt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_out    (ct_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_t[tmp[31:24]], sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ key[127-8*n -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) s[n] = sb_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            s = t;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) begin
                tmp  = w[4*r + n/4];
                s[n] = s[n] ^ tmp[31-8*(n%4) -: 8];
            end
        end
        res = '0;
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    task automatic accept(input logic [127:0] k, input logic [127:0] p);
        int guard;
        guard    = 0;
        key_in   = k;
        pt_in    = p;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) check("valid_timeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc1, acc2, c, stray, hs, unstable, extra;
        logic         pre, seen1, got, done;
        logic [127:0] ct1, held, k, p, e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key_in = '0; pt_in = '0;
        build_sbox();
        step();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ct", ct_out, 128'd0);
        step();
        rst = 1'b0;

        // FIPS-197 C.1 with latency
        out_ready = 1'b1;
        accept(C1_KEY, C1_PT);
        check("c1_busy", 128'(busy), 128'd1);
        check("c1_in_ready_busy", 128'(in_ready), 128'd0);
        wait_valid(lat);
        check("c1_latency", 128'(lat), 128'd10);
        check("c1_ct", ct_out, C1_CT);
        check("c1_done_busy", 128'(busy), 128'd0);
        step();
        check("c1_after_valid", 128'(out_valid), 128'd0);
        check("c1_after_ready", 128'(in_ready), 128'd1);
        check("c1_ct_hold", ct_out, C1_CT);

        // FIPS-197 App. B with round-key checkpoints
        accept(B_KEY, B_PT);
        step();
        check("b_rk1", dut.rk_q, B_RK1);
        wait_valid(lat);
        check("b_rk10", dut.rk_q, B_RK10);
        check("b_ct", ct_out, B_CT);
        step();

        // all-zero block under prolonged backpressure
        out_ready = 1'b0;
        accept('0, '0);
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            check("z_ct_hold", ct_out, Z_CT);
            check("z_in_ready", 128'(in_ready), 128'd0);
            check("z_out_valid", 128'(out_valid), 128'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        check("z_release_ready", 128'(in_ready), 128'd1);
        check("z_release_valid", 128'(out_valid), 128'd0);

        // back-to-back with in_valid held high
        key_in = C1_KEY; pt_in = C1_PT; in_valid = 1'b1;
        acc1 = -1; acc2 = -1; c = 0; seen1 = 1'b0; ct1 = '0;
        for (int i = 0; i < 60 && acc2 < 0; i++) begin
            pre = in_ready;
            step();
            c++;
            if (pre) begin
                if (acc1 < 0) begin
                    acc1 = c;
                    key_in = B_KEY;
                    pt_in  = B_PT;
                end else begin
                    acc2 = c;
                end
            end
            if (out_valid && !seen1) begin
                seen1 = 1'b1;
                ct1   = ct_out;
            end
        end
        in_valid = 1'b0;
        check("b2b_gap", 128'(acc2 - acc1), 128'd12);
        check("b2b_ct1", ct1, C1_CT);
        wait_valid(lat);
        check("b2b_ct2", ct_out, B_CT);
        step();

        // reset in the middle of an encryption
        accept(C1_KEY, C1_PT);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_ready", 128'(in_ready), 128'd1);
        check("mid_rst_ct", ct_out, 128'd0);
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) stray++;
        end
        check("mid_rst_stray", 128'(stray), 128'd0);
        accept(B_KEY, B_PT);
        wait_valid(lat);
        check("mid_rst_b_ct", ct_out, B_CT);
        step();

        // random blocks with random backpressure
        hs = 0; unstable = 0; extra = 0;
        for (int b = 0; b < 1000; b++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            e = aes_ref(k, p);
            out_ready = 1'b0;
            accept(k, p);
            got = 1'b0; done = 1'b0; held = '0;
            for (int cy = 0; cy < 300 && !done; cy++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid) begin
                    if (!got) begin
                        check("rand_ct", ct_out, e);
                        got  = 1'b1;
                        held = ct_out;
                    end else if (ct_out !== held) begin
                        unstable++;
                    end
                    if (out_ready) begin
                        done = 1'b1;
                        hs++;
                    end
                end
                step();
            end
            if (done && out_valid) extra++;
            if (!done) check("rand_timeout", 128'(done), 128'd1);
        end
        check("rand_handshakes", 128'(hs), 128'd1000);
        check("rand_unstable", 128'(unstable), 128'd0);
        check("rand_extra_valid", 128'(extra), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
